// File: rtl/dbns_to_binary_serial.sv
// Serial DBNS-to-binary converter: captures a six-slot DBNS sum plus three upper-slot
// carries, then accumulates one weighted term per cycle into an OUT_W-bit result.
module dbns_to_binary_serial #(
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned W000        = 1,
  parameter int unsigned W001        = 3,
  parameter int unsigned W010        = 9,
  parameter int unsigned W100        = 2,
  parameter int unsigned W101        = 6,
  parameter int unsigned W110        = 18,
  parameter int unsigned CARRY_SCALE = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       d000,
  input  logic [3:0]       d001,
  input  logic [3:0]       d010,
  input  logic [3:0]       d100,
  input  logic [3:0]       d101,
  input  logic [3:0]       d110,
  input  logic [1:0]       c100,
  input  logic [1:0]       c101,
  input  logic [1:0]       c110,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshakes: a word transfers on a rising edge where in_valid && in_ready; a result
  // transfers on a rising edge where out_valid && out_ready. Both readies/valids are registered.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough that no term or partial sum can lose bits before the overflow test.
  localparam int unsigned SUM_W = OUT_W + 33;

  state_t           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [3:0]       d000_q, d000_d, d001_q, d001_d, d010_q, d010_d;
  logic [3:0]       d100_q, d100_d, d101_q, d101_d, d110_q, d110_d;
  logic [1:0]       c100_q, c100_d, c101_q, c101_d, c110_q, c110_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      term;
  logic [SUM_W-1:0] sum;

  always_comb begin
    term = '0;
    case (k_q)
      4'd0:    term = 32'(d000_q) * W000;
      4'd1:    term = 32'(d001_q) * W001;
      4'd2:    term = 32'(d010_q) * W010;
      4'd3:    term = 32'(d100_q) * W100;
      4'd4:    term = 32'(d101_q) * W101;
      4'd5:    term = 32'(d110_q) * W110;
      4'd6:    term = 32'(c100_q) * CARRY_SCALE * W100;
      4'd7:    term = 32'(c101_q) * CARRY_SCALE * W101;
      4'd8:    term = 32'(c110_q) * CARRY_SCALE * W110;
      default: term = '0;
    endcase
    sum = SUM_W'(acc_q) + SUM_W'(term);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    d000_d      = d000_q;
    d001_d      = d001_q;
    d010_d      = d010_q;
    d100_d      = d100_q;
    d101_d      = d101_q;
    d110_d      = d110_q;
    c100_d      = c100_q;
    c101_d      = c101_q;
    c110_d      = c110_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d000_d     = d000;
          d001_d     = d001;
          d010_d     = d010;
          d100_d     = d100;
          d101_d     = d101;
          d110_d     = d110;
          c100_d     = c100;
          c101_d     = c101;
          c110_d     = c110;
          acc_d      = '0;
          ovf_d      = 1'b0;
          k_d        = 4'd0;
          in_ready_d = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = sum[OUT_W-1:0];
        ovf_d = ovf_q | (|sum[SUM_W-1:OUT_W]);
        k_d   = k_q + 4'd1;
        if (k_q == 4'd8) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      d000_q      <= '0;
      d001_q      <= '0;
      d010_q      <= '0;
      d100_q      <= '0;
      d101_q      <= '0;
      d110_q      <= '0;
      c100_q      <= '0;
      c101_q      <= '0;
      c110_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      d000_q      <= d000_d;
      d001_q      <= d001_d;
      d010_q      <= d010_d;
      d100_q      <= d100_d;
      d101_q      <= d101_d;
      d110_q      <= d110_d;
      c100_q      <= c100_d;
      c101_q      <= c101_d;
      c110_q      <= c110_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dbns_to_binary_serial.sv
// Bench for dbns_to_binary_serial: a 16-bit and a 10-bit instance run in lockstep,
// checked by a scoreboard fed from an arithmetic DBNS reference model.
module tb_dbns_to_binary_serial;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  d000, d001, d010, d100, d101, d110;
  logic [1:0]  c100, c101, c110;
  logic        out_ready;

  logic        in_ready16, out_valid16, ovf16;
  logic [15:0] result16;
  logic [1:0]  dbg16;
  logic        in_ready10, out_valid10, ovf10;
  logic [9:0]  result10;
  logic [1:0]  dbg10;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;  // 0: random, 1: hold low, 2: hold high

  logic [16:0] exp16_q[$];
  logic [10:0] exp10_q[$];

  always #5 clock = ~clock;

  dbns_to_binary_serial u_dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .d000(d000), .d001(d001), .d010(d010), .d100(d100), .d101(d101), .d110(d110),
    .c100(c100), .c101(c101), .c110(c110),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
    .overflow(ovf16), .dbg_state(dbg16)
  );

  dbns_to_binary_serial #(.OUT_W(10)) u_dut10 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready10),
    .d000(d000), .d001(d001), .d010(d010), .d100(d100), .d101(d101), .d110(d110),
    .c100(c100), .c101(c101), .c110(c110),
    .out_valid(out_valid10), .out_ready(out_ready), .result(result10),
    .overflow(ovf10), .dbg_state(dbg10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Word layout: {d000,d001,d010,d100,d101,d110,c100,c101,c110}.
  // Slot i has exponents (a,b) = (i/3, i%3) and weight 2^a*3^b; carries sit on slots 3..5.
  function automatic int model_sum(input logic [29:0] w);
    int s;
    int wt[6];
    s = 0;
    for (int i = 0; i < 6; i++) begin
      wt[i] = 1 << (i / 3);
      for (int j = 0; j < (i % 3); j++) wt[i] = wt[i] * 3;
    end
    for (int i = 0; i < 6; i++) s += int'(w[29 - 4*i -: 4]) * wt[i];
    for (int i = 0; i < 3; i++) s += int'(w[5 - 2*i -: 2]) * 16 * wt[i + 3];
    return s;
  endfunction

  task automatic push_expected(input logic [29:0] w);
    int s;
    s = model_sum(w);
    exp16_q.push_back({s > 65535, 16'(s % 65536)});
    exp10_q.push_back({s > 1023, 10'(s % 1024)});
  endtask

  task automatic send_word(input logic [29:0] w);
    int n;
    n = 0;
    @(negedge clock);
    {d000, d001, d010, d100, d101, d110, c100, c101, c110} = w;
    in_valid = 1'b1;
    while (!in_ready16 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready16) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      push_expected(w);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      {d000, d001, d010, d100, d101, d110, c100, c101, c110} = 30'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp16_q.size() != 0 || exp10_q.size() != 0 || !in_ready16) && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp16_q.size());
    end
  endtask

  // Monitor: drives out_ready and scores every result handshake.
  always @(negedge clock) begin
    logic [16:0] e16;
    logic [10:0] e10;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 2) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    if (reset_n) begin
      if (out_valid16 && out_ready) begin
        if (exp16_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected16: got result %0d expected no output", result16);
        end else begin
          e16 = exp16_q.pop_front();
          check("result16", 32'(result16), 32'(e16[15:0]));
          check("ovf16", 32'(ovf16), 32'(e16[16]));
        end
      end
      if (out_valid10 && out_ready) begin
        if (exp10_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected10: got result %0d expected no output", result10);
        end else begin
          e10 = exp10_q.pop_front();
          check("result10", 32'(result10), 32'(e10[9:0]));
          check("ovf10", 32'(ovf10), 32'(e10[10]));
        end
      end
    end
  end

  initial begin
    int n;
    logic [29:0] w;
    int s;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {d000, d001, d010, d100, d101, d110, c100, c101, c110} = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready16), 32'd1);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_result", 32'(result16), 32'd0);
    check("rst_overflow", 32'(ovf16), 32'd0);
    check("rst_state", 32'(dbg16), 32'd0);

    // All-zero word: full 9-cycle latency
    send_word(30'd0);
    n = 0;
    while (!out_valid16 && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd9);
    drain();

    // Single-slot and carry words, then the all-ones maximum
    send_word({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 2'd0, 2'd0, 2'd0});
    send_word({4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 2'd2, 2'd0});
    send_word({24'hFFFFFF, 6'h3F});
    drain();

    // Hold out_ready low in DONE for 20 cycles with stray in_valid pulses
    ready_mode = 1;
    w = 30'($urandom);
    s = model_sum(w);
    send_word(w);
    n = 0;
    while (!out_valid16 && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(out_valid16), 32'd1);
      check("hold_result", 32'(result16), 32'(s % 65536));
      check("hold_in_ready", 32'(in_ready16), 32'd0);
      in_valid = ((i % 3) == 0);
      {d000, d001, d010, d100, d101, d110, c100, c101, c110} = 30'($urandom);
    end
    @(posedge clock);
    #1;
    in_valid   = 1'b0;
    ready_mode = 2;
    @(posedge clock);
    #1;
    check("release_state", 32'(dbg16), 32'd0);
    check("release_in_ready", 32'(in_ready16), 32'd1);
    check("release_out_valid", 32'(out_valid16), 32'd0);
    ready_mode = 0;
    drain();

    // Reset during ACCUM at k=4 aborts the word
    send_word({24'hFFFFFF, 6'h3F});
    repeat (4) @(posedge clock);
    #1;
    check("mid_state", 32'(dbg16), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid16), 32'd0);
    check("abort_result", 32'(result16), 32'd0);
    check("abort_result10", 32'(result10), 32'd0);
    check("abort_in_ready", 32'(in_ready16), 32'd1);
    void'(exp16_q.pop_back());
    void'(exp10_q.pop_back());
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    send_word({4'd3, 4'd7, 4'd1, 4'd9, 4'd2, 4'd11, 2'd1, 2'd3, 2'd2});
    drain();

    // Random words with random gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send_word(30'($urandom));
    end
    drain();
    check("leftover16", 32'(exp16_q.size()), 32'd0);
    check("leftover10", 32'(exp10_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
